// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-and-add multiplier that borrows the shared
// combinational ALU (one add per cycle) and returns the low XLEN bits of
// op_a*op_b. The loop stops early once the remaining multiplier bits are zero.
module alu_mul_seq #(
    parameter int XLEN     = 32,
    parameter int MAX_ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [3:0]      alu_func,
    output logic [XLEN-1:0] alu_src1,
    output logic [XLEN-1:0] alu_src2,
    input  logic [XLEN-1:0] alu_ans
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [5:0] CNT_MAX = 6'(MAX_ITER);

    state_t          state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    // Addend for the current iteration: multiplicand when the multiplier LSB is set.
    logic [XLEN-1:0] addend_s;
    // Multiplier after this iteration's shift; zero means no more partial products.
    logic [XLEN-1:0] mplier_shr_s;
    logic [5:0]      cnt_inc_s;

    // Iteration datapath helpers shared by the ALU drive and the next-state logic.
    always_comb begin
        addend_s     = mplier_q[0] ? mcand_q : {XLEN{1'b0}};
        mplier_shr_s = mplier_q >> 1;
        cnt_inc_s    = cnt_q + 6'd1;
    end

    // State and datapath register update; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= {XLEN{1'b0}};
            mcand_q  <= {XLEN{1'b0}};
            mplier_q <= {XLEN{1'b0}};
            cnt_q    <= 6'd0;
            result_q <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Next-state logic: accept in IDLE, one add per RUN cycle, flush aborts.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = {XLEN{1'b0}};
                    cnt_d    = 6'd0;
                    if (op_b == {XLEN{1'b0}}) begin
                        // Zero multiplier: skip the loop, product is zero.
                        state_d  = S_DONE;
                        result_d = {XLEN{1'b0}};
                    end else begin
                        state_d  = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d    = alu_ans;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shr_s;
                cnt_d    = cnt_inc_s;
                if ((mplier_shr_s == {XLEN{1'b0}}) || (cnt_inc_s == CNT_MAX)) begin
                    state_d  = S_DONE;
                    result_d = alu_ans;
                end else begin
                    state_d  = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pipeline kill: drop back to IDLE, keep result and working registers.
        if (flush) begin
            state_d  = S_IDLE;
            acc_d    = acc_q;
            mcand_d  = mcand_q;
            mplier_d = mplier_q;
            cnt_d    = cnt_q;
            result_d = result_q;
        end else begin
            state_d  = state_d;
        end
    end

    // ALU drive: add acc + addend while running, idle values otherwise.
    always_comb begin
        alu_func = ALU_ADD;
        alu_src1 = {XLEN{1'b0}};
        alu_src2 = {XLEN{1'b0}};
        if (state_q == S_RUN) begin
            alu_func = ALU_ADD;
            alu_src1 = acc_q;
            alu_src2 = addend_s;
        end else begin
            alu_func = ALU_ADD;
        end
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        result = result_q;
    end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Iterative 32-bit multiply sequencer that borrows the core's shared combinational ALU to implement MUL without a hardware multiplier. It accepts an operand pair through a start/busy handshake and produces the low 32 bits of the product. It runs a shift-and-add loop, issuing one ALU add per cycle, and terminates early once the remaining multiplier bits are zero. It sits beside the EX stage. The ALU port mux grants the ALU to this block while `busy` is high.

## Interface
- `XLEN`, 32, operand, result and ALU data width; only 32 is supported.
- `MAX_ITER`, 32, hard iteration cap; must equal `XLEN`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `op_a`  in  32  multiplicand; sampled with `start`.
- `op_b`  in  32  multiplier; sampled with `start`.
- `flush`  in  1  pipeline kill; aborts any operation.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  32  low 32 bits of op_a*op_b; held until the next accepted start.
- `alu_func`  out  4  ALU function select.
- `alu_src1`  out  32  ALU operand 1.
- `alu_src2`  out  32  ALU operand 2.
- `alu_ans`  in  32  ALU result, combinational from the `alu_*` outputs.

## Operation
- The clock is `clk` and the reset is `rst`, synchronous and active-high. There is one clock domain.
- The block has three states: IDLE, RUN and DONE.
- Internal registers:
  - `acc`, 32 bits, the partial sum.
  - `mcand`, 32 bits, the shifted multiplicand.
  - `mplier`, 32 bits, the shifted multiplier.
  - `cnt`, 6 bits.
- IDLE with `start`=1 and `flush`=0:
  - Load `mcand`=`op_a`, `mplier`=`op_b`, `acc`=0, `cnt`=0.
  - Go to DONE if `op_b`==0, otherwise go to RUN.
- RUN, combinational outputs:
  - `alu_func`=4'b0000 (add).
  - `alu_src1`=`acc`.
  - `alu_src2`=`mplier[0]` ? `mcand` : 0.
- RUN, at each edge:
  - `acc`<=`alu_ans`.
  - `mcand`<=`mcand`<<1.
  - `mplier`<=`mplier`>>1 (logical).
  - `cnt`<=`cnt`+1.
  - Go to DONE when (`mplier`>>1)==0 or `cnt`+1==`MAX_ITER`.
- DONE:
  - `done`=1 and `result` is valid.
  - `result` is a register loaded from `acc` on the edge that enters DONE.
  - Go to IDLE on the next edge.
- Signedness needs no special handling. The low 32 bits of a two's-complement product equal the low 32 bits of the unsigned product.
- Arithmetic wraps modulo 2^32. Overflow of `acc` is discarded and no flag is raised.
- Outside RUN the ALU outputs are idle: `alu_func`=4'b0000, `alu_src1`=0, `alu_src2`=0.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, `acc`/`mcand`/`mplier`/`cnt`=0, `alu_func`=4'b0000, `alu_src1`/`alu_src2`=0.
- Reset has priority over `flush`. `flush` has priority over `start` and over state advance.
- Let E0 be the edge that samples an accepted `start`. Let k be the index of the highest set bit of `op_b`, plus 1 (k=0 when `op_b`=0).
  - There are exactly k RUN cycles.
  - `done` is high in cycle k+1 after E0.
  - `busy` is high in cycles 1..k+1.
  - Worst-case latency is 33 cycles.
- `start` during RUN or DONE is ignored. It is not queued, and the operands are not resampled.
- `start` in the same cycle as `done` is ignored. The earliest new accept is the cycle after `done`.
- `flush`=1 in any state:
  - State goes to IDLE at the next edge.
  - No `done` pulse is produced and `result` is unchanged.
  - `busy` is 0 from the following cycle.
  - Any `start` in that cycle is dropped.
- Reset mid-RUN: all outputs return to their reset values at the next edge, and no `done` is produced.
- `alu_ans` is consumed only in RUN. The block assumes the ALU is a pure combinational path with no added latency.

## Test plan
- `op_a`=6, `op_b`=7 (k=3) -> `alu_src2` sequence 6, 12, 24 in RUN cycles 1..3. `done` in cycle 4 with `result`=42. `busy` high in cycles 1..4.
- `op_a`=0x12345678, `op_b`=0 -> no RUN cycles. `done` in cycle 1 with `result`=0. `alu_*` outputs stay at their idle values.
- `op_a`=`op_b`=0xFFFFFFFF -> 32 RUN cycles. `done` in cycle 33 with `result`=0x00000001.
- `op_a`=0xFFFFFFFD (-3), `op_b`=5 -> `done` in cycle 4 with `result`=0xFFFFFFF1 (-15).
- Start 6*7, assert `start` with 9*9 in cycle 2 -> second request ignored. `done` in cycle 4 with 42, and no second `done` follows.
- Start 0xFFFFFFFF*0xFFFFFFFF, then `flush` in cycle 10 -> `busy`=0 from cycle 11, no `done`, `result` keeps its prior value. Repeat the run with `rst` in cycle 10 -> all outputs at reset values from cycle 11.
